ps2_scancode_receiver: RTL

//  PS/2 keyboard receiver for Tetrix. Samples the keyboard clock/data lines with the system clock.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_event_fifo.sv | 63 ++++++
 rtl/ps2_scancode_receiver.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, frame FSM encoding and decoded key-event layout for the PS/2 receiver.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;
  localparam int         PS2_DATA_BITS  = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } key_evt_t;

  localparam int KEY_EVT_W = $bits(key_evt_t);

  // PS/2 uses odd parity across the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead event FIFO: head visible combinationally from storage, write lands 1 cycle after push.
// A push while full is dropped (push_drop) unless a pop happens in the same cycle.
module ps2_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] head_dat,
  output logic             head_vld,
  output logic             push_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty, full, pop, wr_en;

  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CW'(DEPTH));
    pop       = !empty && pop_rdy;
    wr_en     = push_vld && (!full || pop);
    push_drop = push_vld && full && !pop;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(wr_en) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign head_vld = !empty;

endmodule

// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard receiver: sync + glitch filter, 11-bit frame FSM, E0/F0 prefix folding, event FIFO.
// Stop-bit fall strobe to key_valid is 2 clk; key_ready stalls the FIFO, full FIFO drops with overflow.
module ps2_scancode_receiver
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       frame_err,
  output logic       overflow,
  output logic [7:0] led_code
);

  localparam int FCW = $clog2(FILTER_LEN) + 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic [FCW-1:0]         filt_cnt_q, filt_cnt_d;
  logic                   filt_q, filt_d;
  logic                   fall_q, fall_d;
  logic                   fall_dat_q, fall_dat_d;
  logic [1:0]             state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_q, par_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   acc_q, acc_d;
  logic [7:0]             acc_byte_q, acc_byte_d;
  logic                   ferr_q, ferr_d;
  logic                   ext_pend_q, ext_pend_d;
  logic                   brk_pend_q, brk_pend_d;
  logic [7:0]             led_code_q, led_code_d;
  logic                   ovf_q, ovf_d;
  logic                   push_vld, push_drop, clk_s, dat_s;
  key_evt_t               push_dat, head_dat;

  // Synchroniser and ps2_clk filter; lines idle high so everything resets to 1.
  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
    clk_s      = clk_sync_q[SYNC_STAGES-1];
    dat_s      = dat_sync_q[SYNC_STAGES-1];
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_s != filt_q) begin
      if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_d = clk_s;
      end else begin
        filt_cnt_d = filt_cnt_q + FCW'(1);
      end
    end
    fall_d     = filt_q && !filt_d;
    fall_dat_d = dat_s;
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    acc_d      = 1'b0;
    acc_byte_d = acc_byte_q;
    ferr_d     = 1'b0;
    tmo_d      = (state_q == ST_IDLE || fall_q) ? '0 : tmo_q + TW'(1);
    case (state_q)
      ST_IDLE: begin
        if (fall_q && !fall_dat_q) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = '0;
        end
      end
      ST_SHIFT: begin
        if (fall_q) begin
          shift_d   = {fall_dat_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (fall_q) begin
          par_d   = fall_dat_q;
          state_d = ST_STOP;
        end
      end
      default: begin
        if (fall_q) begin
          if (fall_dat_q && odd_parity_ok(shift_q, par_q)) begin
            acc_d      = 1'b1;
            acc_byte_d = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
    endcase
    // A stalled keyboard abandons the partial byte but keeps any prefix already seen.
    if (state_q != ST_IDLE && !fall_q && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      ferr_d  = 1'b1;
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    led_code_d = led_code_q;
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    push_vld   = 1'b0;
    push_dat   = '{code: acc_byte_q, ext: ext_pend_q, brk: brk_pend_q};
    if (acc_q) begin
      led_code_d = acc_byte_q;
      if (acc_byte_q == PS2_EXT_PREFIX) begin
        ext_pend_d = 1'b1;
      end else if (acc_byte_q == PS2_BRK_PREFIX) begin
        brk_pend_d = 1'b1;
      end else begin
        push_vld   = 1'b1;
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
      end
    end
    ovf_d = push_drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      filt_cnt_q <= '0;
      filt_q     <= 1'b1;
      fall_q     <= 1'b0;
      fall_dat_q <= 1'b1;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      acc_q      <= 1'b0;
      acc_byte_q <= '0;
      ferr_q     <= 1'b0;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      led_code_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      filt_cnt_q <= filt_cnt_d;
      filt_q     <= filt_d;
      fall_q     <= fall_d;
      fall_dat_q <= fall_dat_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      acc_q      <= acc_d;
      acc_byte_q <= acc_byte_d;
      ferr_q     <= ferr_d;
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
      led_code_q <= led_code_d;
      ovf_q      <= ovf_d;
    end
  end

  ps2_event_fifo #(
    .WIDTH(KEY_EVT_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_rdy  (key_ready),
    .head_dat (head_dat),
    .head_vld (key_valid),
    .push_drop(push_drop)
  );

  assign key_code  = head_dat.code;
  assign key_ext   = head_dat.ext;
  assign key_break = head_dat.brk;
  assign frame_err = ferr_q;
  assign overflow  = ovf_q;
  assign led_code  = led_code_q;

endmodule
